// File: rtl/hist_pkg.sv
// Shared types and width helpers for the histogram readout block.
package hist_pkg;

  // Sweep sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    SEND,
    DONE
  } state_t;

  // Bin address width; a floor of 1 keeps degenerate sizes legal.
  function automatic int addr_w(input int num_bins);
    return (num_bins < 2) ? 1 : $clog2(num_bins);
  endfunction

  // Width of the running total. Each bin is below 2**count_w and there are at
  // most 2**aw bins, so the sum always fits in count_w+aw bits.
  function automatic int total_w(input int count_w, input int aw);
    return count_w + aw;
  endfunction

endpackage

// File: rtl/hist_peak_tracker.sv
// Running peak-bin and total-count accumulator for one histogram sweep.
// clear_i zeroes everything. update_i folds in one (bin, count) sample.
// Bin 0 always loads the peak. A later bin replaces the peak only when it is
// strictly larger, so on a tie the lowest index is kept.
module hist_peak_tracker
  import hist_pkg::*;
#(
  parameter int COUNT_W = 7,
  parameter int ADDR_W  = 7,
  localparam int TOTAL_W = total_w(COUNT_W, ADDR_W)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               clear_i,
  input  logic               update_i,
  input  logic [COUNT_W-1:0] count_i,
  input  logic [ADDR_W-1:0]  bin_i,
  output logic [ADDR_W-1:0]  peak_bin_o,
  output logic [COUNT_W-1:0] peak_count_o,
  output logic [TOTAL_W-1:0] total_o
);

  logic [ADDR_W-1:0]  peak_bin_q,   peak_bin_d;
  logic [COUNT_W-1:0] peak_count_q, peak_count_d;
  logic [TOTAL_W-1:0] total_q,      total_d;

  // Next-state logic: clear wins over update; otherwise hold.
  always_comb begin
    peak_bin_d   = peak_bin_q;
    peak_count_d = peak_count_q;
    total_d      = total_q;
    if (clear_i) begin
      peak_bin_d   = '0;
      peak_count_d = '0;
      total_d      = '0;
    end else if (update_i) begin
      total_d = total_q + TOTAL_W'(count_i);
      if ((bin_i == '0) || (count_i > peak_count_q)) begin
        peak_bin_d   = bin_i;
        peak_count_d = count_i;
      end
    end
  end

  // Accumulator registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      peak_bin_q   <= '0;
      peak_count_q <= '0;
      total_q      <= '0;
    end else begin
      peak_bin_q   <= peak_bin_d;
      peak_count_q <= peak_count_d;
      total_q      <= total_d;
    end
  end

  assign peak_bin_o   = peak_bin_q;
  assign peak_count_o = peak_count_q;
  assign total_o      = total_q;

endmodule

// File: rtl/histogram_readout.sv
// Histogram bin-memory reader. It sweeps bins 0..NUM_BINS-1 through a
// 1-cycle-latency RAM read port and streams (bin, count) beats over a
// valid/ready interface. While it sweeps, it tracks the peak bin and the
// total count.
// Optional macro HIST_CLEAR_ON_READ_EN: each bin is written back to zero in
// the cycle its beat is accepted.
module histogram_readout
  import hist_pkg::*;
#(
  parameter int NUM_BINS = 128,
  parameter int COUNT_W  = 7,
  localparam int ADDR_W  = addr_w(NUM_BINS),
  localparam int TOTAL_W = total_w(COUNT_W, ADDR_W)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [COUNT_W-1:0] mem_rd_data,
  output logic               mem_wr_en,
  output logic [COUNT_W-1:0] mem_wr_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_bin,
  output logic [COUNT_W-1:0] out_count,
  output logic               out_last,
  output logic [ADDR_W-1:0]  peak_bin,
  output logic [COUNT_W-1:0] peak_count,
  output logic [TOTAL_W-1:0] total
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BINS - 1);

  state_t             state_q,     state_d;
  logic [ADDR_W-1:0]  addr_q,      addr_d;
  logic [ADDR_W-1:0]  out_bin_q,   out_bin_d;
  logic [COUNT_W-1:0] out_count_q, out_count_d;
  logic               out_last_q,  out_last_d;

  logic accept;
  logic sweep_start;
  logic sample_en;

  assign accept      = (state_q == SEND) && out_ready;
  assign sweep_start = (state_q == IDLE) && start;
  assign sample_en   = (state_q == LATCH);

  // Sequencer next state, address counter and beat register.
  // The address only advances on an accepted beat that is not the last one,
  // so it never goes past NUM_BINS-1 and never wraps.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    out_bin_d   = out_bin_q;
    out_count_d = out_count_q;
    out_last_d  = out_last_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          addr_d  = '0;
        end
      end
      FETCH: begin
        state_d = LATCH;
      end
      LATCH: begin
        out_count_d = mem_rd_data;
        out_bin_d   = addr_q;
        out_last_d  = (addr_q == LAST_ADDR);
        state_d     = SEND;
      end
      SEND: begin
        if (accept) begin
          if (out_last_q) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset aborts any sweep immediately.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      out_bin_q   <= '0;
      out_count_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      out_bin_q   <= out_bin_d;
      out_count_q <= out_count_d;
      out_last_q  <= out_last_d;
    end
  end

  // Peak and total follow the RAM sample taken in LATCH.
  hist_peak_tracker #(
    .COUNT_W (COUNT_W),
    .ADDR_W  (ADDR_W)
  ) u_peak (
    .CLK          (CLK),
    .RST          (RST),
    .clear_i      (sweep_start),
    .update_i     (sample_en),
    .count_i      (mem_rd_data),
    .bin_i        (addr_q),
    .peak_bin_o   (peak_bin),
    .peak_count_o (peak_count),
    .total_o      (total)
  );

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign out_valid = (state_q == SEND);
  assign out_bin   = out_bin_q;
  assign out_count = out_count_q;
  assign out_last  = out_last_q;
  assign mem_addr  = addr_q;

  // In SEND, addr_q still equals out_bin, so the write-back lands on the bin
  // that was just delivered.
`ifdef HIST_CLEAR_ON_READ_EN
  assign mem_wr_en = accept;
`else
  assign mem_wr_en = 1'b0;
`endif
  assign mem_wr_data = '0;

endmodule

// File: tb/tb_histogram_readout.sv
// Testbench for histogram_readout with NUM_BINS=16 and COUNT_W=7.
// A behavioural RAM model serves the DUT. For each sweep, the expected beats
// are queued when the sweep starts and are popped as the DUT delivers them.
module tb_histogram_readout;

  localparam int N  = 16;
  localparam int CW = 7;
  localparam int AW = 4;
  localparam int TW = 11;

  typedef struct packed {
    logic [AW-1:0] bin;
    logic [CW-1:0] cnt;
    logic          last;
  } beat_t;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          start = 1'b0;
  logic          out_ready;
  logic          busy, done, mem_wr_en, out_valid, out_last;
  logic [AW-1:0] mem_addr, out_bin, peak_bin;
  logic [CW-1:0] mem_rd_data, mem_wr_data, out_count, peak_count;
  logic [TW-1:0] total;

  logic [CW-1:0] ram [N];
  logic [CW-1:0] rd_q;
  logic          fill_en = 1'b0;
  logic [AW-1:0] fill_addr = '0;
  logic [CW-1:0] fill_data = '0;
  bit            bp_en = 1'b0;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    beats = 0;
  int    done_cnt = 0;
  int    wr_cnt = 0;
  int    ep_bin, ep_cnt, ep_tot;

  always #5 CLK = ~CLK;

  histogram_readout #(.NUM_BINS(N), .COUNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .start(start), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_bin(out_bin), .out_count(out_count), .out_last(out_last),
    .peak_bin(peak_bin), .peak_count(peak_count), .total(total)
  );

  // Synchronous-read RAM. The bench fill port has priority over DUT writes.
  always @(posedge CLK) begin
    if (fill_en) ram[fill_addr] <= fill_data;
    else if (mem_wr_en) ram[mem_addr] <= mem_wr_data;
    rd_q <= ram[mem_addr];
  end
  assign mem_rd_data = rd_q;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // out_ready driver: tied high, or low roughly 30% of cycles under backpressure.
  initial forever begin
    @(posedge CLK);
    #1;
    out_ready = bp_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
  end

  // Stream monitor: checks hold-while-stalled and scoreboards accepted beats.
  initial begin
    bit    stall;
    beat_t held;
    beat_t e;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        stall = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (mem_wr_en) begin
          wr_cnt++;
          check_eq("wr_addr", mem_addr, out_bin);
        end
        if (stall) begin
          check_eq("hold_valid", out_valid, 1);
          check_eq("hold_bin", out_bin, held.bin);
          check_eq("hold_count", out_count, held.cnt);
          check_eq("hold_last", out_last, held.last);
        end
        if (out_valid && out_ready) begin
          beats++;
          check_eq("queue_nonempty", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("beat_bin", out_bin, e.bin);
            check_eq("beat_count", out_count, e.cnt);
            check_eq("beat_last", out_last, e.last);
          end
        end
        stall = out_valid && !out_ready;
        held  = '{bin: out_bin, cnt: out_count, last: out_last};
      end
    end
  end

  // Pattern 0: i%8. Pattern 1: all zero. Pattern 2: bins 3 and 9 = 127.
  task automatic fill(input int mode);
    fill_en = 1'b1;
    for (int i = 0; i < N; i++) begin
      fill_addr = AW'(i);
      case (mode)
        0:       fill_data = CW'(i % 8);
        1:       fill_data = '0;
        default: fill_data = (i == 3 || i == 9) ? CW'(127) : CW'(0);
      endcase
      @(posedge CLK);
      #1;
    end
    fill_en = 1'b0;
  endtask

  // Queue the expected beats and compute the expected peak and total from
  // the current RAM contents.
  task automatic push_expect();
    beat_t b;
    int    c;
    ep_bin = 0;
    ep_cnt = 0;
    ep_tot = 0;
    for (int i = 0; i < N; i++) begin
      c = int'(ram[i]);
      b = '{bin: AW'(i), cnt: ram[i], last: (i == N - 1)};
      exp_q.push_back(b);
      ep_tot += c;
      if (i == 0 || c > ep_cnt) begin
        ep_bin = i;
        ep_cnt = c;
      end
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_valid"}, out_valid, 0);
    check_eq({tag, "_addr"}, mem_addr, 0);
    check_eq({tag, "_wr_en"}, mem_wr_en, 0);
    check_eq({tag, "_wr_data"}, mem_wr_data, 0);
    check_eq({tag, "_bin"}, out_bin, 0);
    check_eq({tag, "_count"}, out_count, 0);
    check_eq({tag, "_last"}, out_last, 0);
    check_eq({tag, "_peak_bin"}, peak_bin, 0);
    check_eq({tag, "_peak_cnt"}, peak_count, 0);
    check_eq({tag, "_total"}, total, 0);
  endtask

  task automatic run_sweep(input string name, input bit poke);
    int n;
    int d0;
    int nz;
    push_expect();
    beats  = 0;
    wr_cnt = 0;
    d0     = done_cnt;
    start  = 1'b1;
    n      = 0;
    do begin
      @(posedge CLK);
      #1;
      n++;
      if (n == 1) check_eq({name, "_busy_on"}, busy, 1);
      start = poke && (n == 10 || n == 25);
    end while (!done && n < 1000);
    start = 1'b0;
    check_eq({name, "_done_seen"}, done, 1);
    // The cycle that carries start and the done cycle are both counted.
    if (!bp_en) check_eq({name, "_latency"}, n + 1, 3 * N + 2);
    repeat (4) @(posedge CLK);
    #1;
    check_eq({name, "_done_pulses"}, done_cnt - d0, 1);
    check_eq({name, "_busy_off"}, busy, 0);
    check_eq({name, "_beats"}, beats, N);
    check_eq({name, "_leftover"}, exp_q.size(), 0);
    check_eq({name, "_peak_bin"}, peak_bin, ep_bin);
    check_eq({name, "_peak_cnt"}, peak_count, ep_cnt);
    check_eq({name, "_total"}, total, ep_tot);
`ifdef HIST_CLEAR_ON_READ_EN
    nz = 0;
    for (int i = 0; i < N; i++) if (ram[i] != '0) nz++;
    check_eq({name, "_wr_cnt"}, wr_cnt, N);
    check_eq({name, "_ram_nonzero"}, nz, 0);
`else
    nz = 0;
    check_eq({name, "_wr_cnt"}, wr_cnt, nz);
`endif
    $display("sweep %s: cycles=%0d beats=%0d peak_bin=%0d peak_count=%0d total=%0d",
             name, n + 1, beats, peak_bin, peak_count, total);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    // Reset at power-up.
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_idle("por");
    RST = 1'b1;
    @(posedge CLK);
    #1;

    // Pattern i%8 with no backpressure.
    fill(0);
    run_sweep("mod8", 1'b0);
    check_eq("mod8_peak_bin_k", peak_bin, 7);
    check_eq("mod8_peak_cnt_k", peak_count, 7);
    check_eq("mod8_total_k", total, 56);

    // Reset in the middle of a sweep.
    fill(0);
    push_expect();
    d0 = done_cnt;
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    repeat (20) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    check_idle("midrst");
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    exp_q.delete();
    repeat (3) @(posedge CLK);
    #1;
    check_eq("midrst_idle", busy, 0);
    check_eq("midrst_no_done", done_cnt - d0, 0);
    $display("sweep midrst: aborted by reset");

    // Backpressure sweep.
    fill(0);
    bp_en = 1'b1;
    run_sweep("bp", 1'b0);
    bp_en = 1'b0;
    @(posedge CLK);
    #1;

    // All bins zero.
    fill(1);
    run_sweep("zero", 1'b0);
    check_eq("zero_peak_bin_k", peak_bin, 0);
    check_eq("zero_peak_cnt_k", peak_count, 0);
    check_eq("zero_total_k", total, 0);

    // Tied maxima at bins 3 and 9.
    fill(2);
    run_sweep("tie", 1'b0);
    check_eq("tie_peak_bin_k", peak_bin, 3);
    check_eq("tie_peak_cnt_k", peak_count, 127);
    check_eq("tie_total_k", total, 254);

    // Start pulses during a sweep are ignored; then a back-to-back repeat sweep.
    fill(0);
    run_sweep("poke", 1'b1);
    run_sweep("again", 1'b0);
`ifdef HIST_CLEAR_ON_READ_EN
    check_eq("again_total_k", total, 0);
`else
    check_eq("again_total_k", total, 56);
    check_eq("again_peak_bin_k", peak_bin, 7);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
